// File: rtl/m_sum_acc_if.sv
// Handshake bundle between the ripple adder, the sum accumulator and its consumer.
// slave is the accumulator side; master is the upstream/downstream driver side.
interface m_sum_acc_if #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8,
    parameter int COUNT = 4,
    parameter int CNT_W = $clog2(COUNT + 1)
);
    logic             w_in_valid;
    logic [IN_W-1:0]  w_in_data;
    logic             w_in_ready;
    logic             w_flush;
    logic             w_out_valid;
    logic [ACC_W-1:0] w_out_sum;
    logic             w_out_ovf;
    logic [CNT_W-1:0] w_out_cnt;
    logic             w_out_ready;

    modport slave (
        input  w_in_valid,
        input  w_in_data,
        output w_in_ready,
        input  w_flush,
        output w_out_valid,
        output w_out_sum,
        output w_out_ovf,
        output w_out_cnt,
        input  w_out_ready
    );

    modport master (
        output w_in_valid,
        output w_in_data,
        input  w_in_ready,
        output w_flush,
        input  w_out_valid,
        input  w_out_sum,
        input  w_out_ovf,
        input  w_out_cnt,
        output w_out_ready
    );
endinterface

// File: rtl/m_sum_acc.sv
// Accumulates COUNT adder sums (or a flushed partial group) into one registered result.
// Define SUM_ACC_SATURATE_EN to clamp overflowing groups to all-ones instead of wrapping.
module m_sum_acc #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8,
    parameter int COUNT = 4,
    parameter int CNT_W = $clog2(COUNT + 1)
) (
    input  logic         w_clk,
    input  logic         w_rst,
    m_sum_acc_if.slave   sum_bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT - 1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_ovf;
    logic [CNT_W-1:0] r_out_cnt;

    logic             in_ready;
    logic             in_fire;
    logic             out_fire;
    logic             at_last;
    logic             close;
    logic [ACC_W:0]   nsum;
    logic             carry;
    logic             ovf_step;
    logic [ACC_W-1:0] acc_step;
    logic [ACC_W-1:0] grp_sum;
    logic             grp_ovf;
    logic [CNT_W-1:0] grp_cnt;

    // A flush is only honoured when in_ready is high, so a blocked flush cannot
    // overwrite a result that is still waiting for the consumer.
    always_comb begin
        at_last  = (r_cnt == LAST_BEAT);
        in_ready = !(r_out_valid && !sum_bus.w_out_ready && (at_last || sum_bus.w_flush));
        in_fire  = sum_bus.w_in_valid && in_ready;
        out_fire = r_out_valid && sum_bus.w_out_ready;
        close    = (in_fire && at_last)
                 || (sum_bus.w_flush && in_ready && (in_fire || (r_cnt != '0)));
    end

    always_comb begin
        nsum     = {1'b0, r_acc} + (ACC_W + 1)'(sum_bus.w_in_data);
        carry    = nsum[ACC_W];
        ovf_step = r_ovf | carry;
`ifdef SUM_ACC_SATURATE_EN
        // Once saturated, any further beat either carries again or adds zero to all-ones.
        acc_step = ovf_step ? {ACC_W{1'b1}} : nsum[ACC_W-1:0];
`else
        acc_step = nsum[ACC_W-1:0];
`endif
        grp_sum  = in_fire ? acc_step : r_acc;
        grp_ovf  = in_fire ? ovf_step : r_ovf;
        grp_cnt  = r_cnt + CNT_W'(in_fire);
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (close) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (in_fire) begin
            r_acc <= acc_step;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= ovf_step;
        end
    end

    // Loading a new result while the old one is taken keeps valid high with no bubble.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_cnt   <= '0;
        end else if (close) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= grp_sum;
            r_out_ovf   <= grp_ovf;
            r_out_cnt   <= grp_cnt;
        end else if (out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign sum_bus.w_in_ready  = in_ready;
    assign sum_bus.w_out_valid = r_out_valid;
    assign sum_bus.w_out_sum   = r_out_sum;
    assign sum_bus.w_out_ovf   = r_out_ovf;
    assign sum_bus.w_out_cnt   = r_out_cnt;

endmodule
